// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencer: op codes, FSM state encoding and
// default latencies of the downstream multiplier and divider.
package hilo_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam int MULT_LAT_DEF = 34;
  localparam int DIV_LAT_DEF  = 34;
  localparam int CNT_W_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DIV_RUN = 2'b10,
    ST_CAPTURE = 2'b11
  } state_t;

endpackage

// File: rtl/hilo_lat_counter.sv
// Loadable down-counter that times the multiplier/divider latency; it saturates
// at zero and flags when the count has run out.
module hilo_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: launches MULT/DIV, times their fixed latency and captures the
// result; handles MTHI/MTLO. Optional flush input enabled by HILO_ABORT_EN.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef HILO_ABORT_EN
  input  logic        abort,
`endif
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        mult_init,
  output logic        mult_stop,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_init,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  state_t           state, state_nxt;
  logic             is_mult, is_mult_nxt;
  logic             busy_nxt, done_nxt, dz_nxt;
  logic             mult_init_nxt, mult_stop_nxt, div_init_nxt;
  logic [31:0]      mult_a_nxt, mult_b_nxt, div_a_nxt, div_b_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  hilo_lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    is_mult_nxt   = is_mult;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    dz_nxt        = 1'b0;
    mult_init_nxt = 1'b0;
    mult_stop_nxt = 1'b0;
    div_init_nxt  = 1'b0;
    mult_a_nxt    = mult_a;
    mult_b_nxt    = mult_b;
    div_a_nxt     = div_a;
    div_b_nxt     = div_b;
    hi_nxt        = hi_q;
    lo_nxt        = lo_q;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_en        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MULT: begin
              mult_a_nxt    = op_a;
              mult_b_nxt    = op_b;
              mult_init_nxt = 1'b1;
              cnt_load      = 1'b1;
              cnt_load_val  = CNT_W'(MULT_LAT - 1);
              is_mult_nxt   = 1'b1;
              busy_nxt      = 1'b1;
              state_nxt     = ST_MUL_RUN;
            end
            OP_DIV: begin
              if (op_b == 32'd0) begin
                dz_nxt = 1'b1;
              end else begin
                div_a_nxt    = op_a;
                div_b_nxt    = op_b;
                div_init_nxt = 1'b1;
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(DIV_LAT - 1);
                is_mult_nxt  = 1'b0;
                busy_nxt     = 1'b1;
                state_nxt    = ST_DIV_RUN;
              end
            end
            OP_MTHI: begin
              hi_nxt   = op_a;
              done_nxt = 1'b1;
            end
            default: begin
              lo_nxt   = op_a;
              done_nxt = 1'b1;
            end
          endcase
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (cnt_zero) state_nxt = ST_CAPTURE;
        else          cnt_en    = 1'b1;
      end
      default: begin
        hi_nxt        = is_mult ? mult_hi : div_hi;
        lo_nxt        = is_mult ? mult_lo : div_lo;
        mult_stop_nxt = is_mult;
        done_nxt      = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = ST_IDLE;
      end
    endcase

`ifdef HILO_ABORT_EN
    // A flush wins over capture: the in-flight result is discarded entirely.
    if (abort && (state != ST_IDLE)) begin
      state_nxt     = ST_IDLE;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      mult_stop_nxt = (state == ST_MUL_RUN);
      hi_nxt        = hi_q;
      lo_nxt        = lo_q;
      cnt_en        = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_mult      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      mult_init    <= 1'b0;
      mult_stop    <= 1'b0;
      div_init     <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
      div_a        <= '0;
      div_b        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      is_mult      <= is_mult_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      div_zero_exc <= dz_nxt;
      mult_init    <= mult_init_nxt;
      mult_stop    <= mult_stop_nxt;
      div_init     <= div_init_nxt;
      mult_a       <= mult_a_nxt;
      mult_b       <= mult_b_nxt;
      div_a        <= div_a_nxt;
      div_b        <= div_b_nxt;
      hi_q         <= hi_nxt;
      lo_q         <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: vector table with a HI/LO scoreboard,
// behavioural multiplier/divider stubs, and hand-written reset/abort sequences.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int MULT_LAT = 34;
  localparam int DIV_LAT  = 34;
  localparam logic [31:0] GARB = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
`ifdef HILO_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero_exc, mult_init, mult_stop, div_init;
  logic [31:0] mult_a, mult_b, div_a, div_b, hi_q, lo_q;
  logic [31:0] mult_hi = 32'd0, mult_lo = 32'd0, div_hi = 32'd0, div_lo = 32'd0;

  hilo_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef HILO_ABORT_EN
    .abort        (abort),
`endif
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .mult_init    (mult_init),
    .mult_stop    (mult_stop),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_hi      (mult_hi),
    .mult_lo      (mult_lo),
    .div_init     (div_init),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_hi       (div_hi),
    .div_lo       (div_lo),
    .hi_q         (hi_q),
    .lo_q         (lo_q)
  );

  always #5 clk = ~clk;

  // Multiplier/divider stubs: garbage until the latency has elapsed after init.
  int mcnt = -1;
  int dcnt = -1;
  always @(posedge clk) begin
    if (mult_init) begin
      mcnt <= MULT_LAT - 2;
      mult_hi <= GARB;
      mult_lo <= GARB;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 0) begin
      {mult_hi, mult_lo} <= $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
      mcnt <= -1;
    end
  end
  always @(posedge clk) begin
    if (div_init) begin
      dcnt <= DIV_LAT - 2;
      div_hi <= GARB;
      div_lo <= GARB;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
    end else if (dcnt == 0) begin
      if (div_b != 32'd0) begin
        div_lo <= $signed(div_a) / $signed(div_b);
        div_hi <= $signed(div_a) % $signed(div_b);
      end
      dcnt <= -1;
    end
  end

  typedef struct {
    logic [1:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[10];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi = 32'd0, cur_lo = 32'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where done was seen (or bound hit).
  task automatic run_op(input vec_t v, input int inj);
    int   done_c, busy_n, init_n, stop_n, dz_n, lim, lat;
    bit   hold_ok, launch;
    exp_t e;
    launch = (v.code == OP_MULT) || (v.code == OP_DIV && !v.dz);
    lat    = (v.code == OP_MULT) ? MULT_LAT : DIV_LAT;
    lim    = v.dz ? 3 : lat + 6;
    op_valid = 1'b1; op_code = v.code; op_a = v.a; op_b = v.b;
    if (!v.dz) sb.push_back('{hi: v.hi, lo: v.lo});
    done_c = 0; busy_n = 0; init_n = 0; stop_n = 0; dz_n = 0; hold_ok = 1'b1;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (c == 1) begin
        op_valid = 1'b0;
        if (v.code == OP_MULT) chk("mult_operands", {mult_a, mult_b}, {v.a, v.b});
        if (v.code == OP_DIV && !v.dz) chk("div_operands", {div_a, div_b}, {v.a, v.b});
      end
      if (inj != 0 && c == inj) begin
        op_valid = 1'b1; op_code = OP_MTLO; op_a = 32'h1;
      end
      if (inj != 0 && c == inj + 1) op_valid = 1'b0;
      busy_n += int'(busy);
      init_n += int'(mult_init) + int'(div_init);
      stop_n += int'(mult_stop);
      dz_n   += int'(div_zero_exc);
      if (done) begin
        done_c = c;
        break;
      end
      if (hi_q !== cur_hi || lo_q !== cur_lo) hold_ok = 1'b0;
    end
    chk("hilo_hold", 128'(hold_ok), 128'(1));
    if (v.dz) begin
      chk("dz_pulse", 128'(dz_n), 128'(1));
      chk("dz_no_launch", 128'(init_n), 128'(0));
      chk("dz_no_busy", 128'(busy_n), 128'(0));
      chk("dz_no_done", 128'(done_c), 128'(0));
      chk("dz_hilo", {hi_q, lo_q}, {cur_hi, cur_lo});
    end else begin
      chk("done_cycle", 128'(done_c), 128'(launch ? lat + 2 : 1));
      chk("busy_cycles", 128'(busy_n), 128'(launch ? lat + 1 : 0));
      chk("init_pulses", 128'(init_n), 128'(launch ? 1 : 0));
      chk("stop_pulses", 128'(stop_n), 128'(v.code == OP_MULT ? 1 : 0));
      if (done_c != 0 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("hilo_result", {hi_q, lo_q}, {e.hi, e.lo});
      end else begin
        chk("done_timeout", 128'(done_c != 0), 128'(1));
        if (sb.size() > 0) void'(sb.pop_front());
      end
      cur_hi = v.hi;
      cur_lo = v.lo;
    end
  endtask

  initial begin
    tbl[0] = '{OP_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[1] = '{OP_MULT, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    tbl[2] = '{OP_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[3] = '{OP_MULT, 32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0};
    tbl[4] = '{OP_DIV,  32'd100,        32'd7,         32'd2,         32'd14,         1'b0};
    tbl[5] = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};
    tbl[6] = '{OP_DIV,  32'd100,        32'd0,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b1};
    tbl[7] = '{OP_MTHI, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFF2, 1'b0};
    tbl[8] = '{OP_MTLO, 32'h1234_5678,  32'd0,         32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
    tbl[9] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    rst_n = 1'b0; op_valid = 1'b0; op_code = OP_MULT; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, done, div_zero_exc, mult_init, mult_stop, div_init, mult_a, mult_b, div_a, div_b},
        128'(0));
    chk("reset_hilo", {hi_q, lo_q}, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done}, 128'(0));

    for (int i = 0; i < 10; i++) run_op(tbl[i], 0);

    // MTLO arriving mid-MULT must be dropped.
    run_op('{OP_MULT, 32'd6, 32'd9, 32'd0, 32'h36, 1'b0}, 10);

    // Asynchronous reset in the middle of a DIV.
    op_valid = 1'b1; op_code = OP_DIV; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("div_inflight", {busy, div_a}, {1'b1, 32'd1000});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {busy, done, div_zero_exc, mult_init, mult_stop, div_init, mult_a, mult_b, div_a, div_b},
        128'(0));
    chk("async_reset_hilo", {hi_q, lo_q}, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    @(negedge clk);
    run_op('{OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0}, 0);

`ifdef HILO_ABORT_EN
    begin
      int  busy_n, stop_n, done_n;
      bit  hold_ok;
      op_valid = 1'b1; op_code = OP_MULT; op_a = 32'd5; op_b = 32'd5;
      busy_n = 0; stop_n = 0; done_n = 0; hold_ok = 1'b1;
      for (int c = 1; c <= MULT_LAT + 6; c++) begin
        @(negedge clk);
        if (c == 1) op_valid = 1'b0;
        if (c == 5) abort = 1'b1;
        if (c == 6) abort = 1'b0;
        busy_n += int'(busy);
        stop_n += int'(mult_stop);
        done_n += int'(done);
        if (hi_q !== cur_hi || lo_q !== cur_lo) hold_ok = 1'b0;
      end
      chk("abort_stop", 128'(stop_n), 128'(1));
      chk("abort_no_done", 128'(done_n), 128'(0));
      chk("abort_busy_cycles", 128'(busy_n), 128'(5));
      chk("abort_hilo_hold", 128'(hold_ok), 128'(1));
      run_op('{OP_MTHI, 32'hCAFE_F00D, 32'd0, 32'hCAFE_F00D, 32'd12, 1'b0}, 0);
    end
`endif

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
